// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared widths, queue depth and MD queue entry type for the register-file
// write-port arbiter and its MD result FIFO.
package regfile_wr_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int MD_Q_DEPTH = 2;
  localparam int CNT_W      = $clog2(MD_Q_DEPTH + 1);
  localparam int PTR_W      = $clog2(MD_Q_DEPTH);

  // One queued multi-cycle result: destination register and its value.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] waddr;
    logic [DATA_W-1:0]     data;
  } md_entry_t;

endpackage

// File: rtl/regfile_md_fifo.sv
// Two-entry FIFO holding accepted mul/div results until the register-file
// write port is free.  Also compares the live entries against the decode
// stage source registers so the hazard logic can see pending writes.
module regfile_md_fifo
  import regfile_wr_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  md_entry_t             push_entry,
  input  logic                  pop,
  output md_entry_t             head,
  output logic [CNT_W-1:0]      count,
  input  logic [REG_ADDR_W-1:0] q_reg1,
  input  logic [REG_ADDR_W-1:0] q_reg2,
  output logic                  hit1,
  output logic                  hit2
);

  md_entry_t        mem [MD_Q_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             valid [MD_Q_DEPTH];

  // Entry storage needs no reset: only slots covered by count are ever read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  // Occupancy and pointers; a push and pop together leave count unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

  // A slot is live when the queue is full, or it is the head of a 1-entry queue.
  always_comb begin
    for (int i = 0; i < MD_Q_DEPTH; i++) begin
      valid[i] = (count == CNT_W'(MD_Q_DEPTH)) ||
                 ((count == CNT_W'(1)) && (rd_ptr == PTR_W'(i)));
    end
  end

  // Source-register match against live entries; register 0 never hits.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < MD_Q_DEPTH; i++) begin
      if (valid[i] && (mem[i].waddr == q_reg1)) hit1 = 1'b1;
      if (valid[i] && (mem[i].waddr == q_reg2)) hit2 = 1'b1;
    end
    if (q_reg1 == '0) hit1 = 1'b0;
    if (q_reg2 == '0) hit2 = 1'b0;
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: pipeline writeback always wins, queued
// mul/div results fill the idle cycles in acceptance order.
// Optional feature macro: REGFILE_ARB_STARVE_EN adds a starvation counter
// that raises stall_req so the hazard unit can open a slot for the MD queue.
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_reg,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  md_valid,
  input  logic [REG_ADDR_W-1:0] md_reg,
  input  logic [DATA_W-1:0]     md_data,
  output logic                  md_ready,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_wreg,
  output logic [DATA_W-1:0]     rf_wdata,
  input  logic [REG_ADDR_W-1:0] q_reg1,
  input  logic [REG_ADDR_W-1:0] q_reg2,
  output logic                  q_hit1,
  output logic                  q_hit2,
  output logic                  md_pend,
  output logic                  stall_req
);

  logic [CNT_W-1:0] count;
  md_entry_t        head;
  md_entry_t        push_entry;
  logic             push;
  logic             pop;
  logic             wb_req;

  // Ready depends only on the registered count, so a full queue never
  // accepts in the same cycle it pops.  Offers to r0 complete the handshake
  // but are dropped instead of queued.
  assign md_ready   = (count != CNT_W'(MD_Q_DEPTH));
  assign push       = md_valid && md_ready && (md_reg != '0);
  assign push_entry = '{waddr: md_reg, data: md_data};
  assign wb_req     = wb_we && (wb_reg != '0);
  assign pop        = !wb_req && (count != '0);
  assign md_pend    = (count != '0);

  regfile_md_fifo u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (count),
    .q_reg1     (q_reg1),
    .q_reg2     (q_reg2),
    .hit1       (q_hit1),
    .hit2       (q_hit2)
  );

  // Registered write port; address and data hold when nothing is written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we    <= 1'b0;
      rf_wreg  <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= wb_req || pop;
      if (wb_req) begin
        rf_wreg  <= wb_reg;
        rf_wdata <= wb_data;
      end else if (pop) begin
        rf_wreg  <= head.waddr;
        rf_wdata <= head.data;
      end
    end
  end

`ifdef REGFILE_ARB_STARVE_EN
  logic [3:0] starve_cnt;
  logic [3:0] starve_next;

  // Count consecutive cycles a waiting head loses to WB; any MD issue or an
  // empty queue restarts the count.  Saturates rather than wrapping.
  always_comb begin
    starve_next = starve_cnt;
    if ((count == '0) || pop) begin
      starve_next = '0;
    end else if (wb_req && (starve_cnt != 4'hF)) begin
      starve_next = starve_cnt + 4'd1;
    end
  end

  // Counter and stall request; stall drops the cycle after the head issues.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
      stall_req  <= 1'b0;
    end else begin
      starve_cnt <= starve_next;
      stall_req  <= (starve_next >= 4'(STARVE_LIMIT));
    end
  end
`else
  // Feature off: no counter.  The limit is never negative, so this is a
  // constant 0 that still references the parameter.
  assign stall_req = (STARVE_LIMIT < 0);
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
// Starvation checks are active when REGFILE_ARB_STARVE_EN is defined.
module tb_regfile_wr_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_reg = '0;
  logic [31:0] wb_data = '0;
  logic        md_valid = 1'b0;
  logic [4:0]  md_reg = '0;
  logic [31:0] md_data = '0;
  logic [4:0]  q_reg1 = '0;
  logic [4:0]  q_reg2 = '0;
  logic        md_ready;
  logic        rf_we;
  logic [4:0]  rf_wreg;
  logic [31:0] rf_wdata;
  logic        q_hit1;
  logic        q_hit2;
  logic        md_pend;
  logic        stall_req;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a queue of {reg,data}, the expected write port and a
  // count of consecutive lost cycles.
  logic [36:0] mq [$];
  logic        exp_we = 1'b0;
  logic [4:0]  exp_wreg = '0;
  logic [31:0] exp_wdata = '0;
  int          lost = 0;
  logic        exp_stall = 1'b0;

  regfile_wr_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .wb_we     (wb_we),
    .wb_reg    (wb_reg),
    .wb_data   (wb_data),
    .md_valid  (md_valid),
    .md_reg    (md_reg),
    .md_data   (md_data),
    .md_ready  (md_ready),
    .rf_we     (rf_we),
    .rf_wreg   (rf_wreg),
    .rf_wdata  (rf_wdata),
    .q_reg1    (q_reg1),
    .q_reg2    (q_reg2),
    .q_hit1    (q_hit1),
    .q_hit2    (q_hit2),
    .md_pend   (md_pend),
    .stall_req (stall_req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output with what the model predicts right now.
  task automatic check_output();
    logic h1, h2;
    h1 = 1'b0;
    h2 = 1'b0;
    foreach (mq[i]) begin
      if (q_reg1 != 0 && mq[i][36:32] == q_reg1) h1 = 1'b1;
      if (q_reg2 != 0 && mq[i][36:32] == q_reg2) h2 = 1'b1;
    end
    chk("md_ready",  32'(md_ready),  32'(mq.size() < 2));
    chk("md_pend",   32'(md_pend),   32'(mq.size() != 0));
    chk("q_hit1",    32'(q_hit1),    32'(h1));
    chk("q_hit2",    32'(q_hit2),    32'(h2));
    chk("rf_we",     32'(rf_we),     32'(exp_we));
    chk("rf_wreg",   32'(rf_wreg),   32'(exp_wreg));
    chk("rf_wdata",  rf_wdata,       exp_wdata);
    chk("stall_req", 32'(stall_req), 32'(exp_stall));
  endtask

  // Advance the model by one clock using the currently driven inputs.
  task automatic model_update();
    logic        accept;
    logic [36:0] e;
    accept = md_valid && (mq.size() < 2);
    if (wb_we && wb_reg != 0) begin
      exp_we    = 1'b1;
      exp_wreg  = wb_reg;
      exp_wdata = wb_data;
      if (mq.size() != 0) lost++;
      else lost = 0;
    end else if (mq.size() != 0) begin
      e         = mq.pop_front();
      exp_we    = 1'b1;
      exp_wreg  = e[36:32];
      exp_wdata = e[31:0];
      lost      = 0;
    end else begin
      exp_we = 1'b0;
      lost   = 0;
    end
`ifdef REGFILE_ARB_STARVE_EN
    exp_stall = (lost >= LIMIT);
`else
    exp_stall = 1'b0;
`endif
    if (accept && md_reg != 0) mq.push_back({md_reg, md_data});
  endtask

  // Drive one cycle of inputs away from the rising edge, check, then model.
  task automatic apply_stimulus(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                                input logic mv, input logic [4:0] mr, input logic [31:0] mdat,
                                input logic [4:0] r1, input logic [4:0] r2);
    @(negedge clk);
    wb_we = we; wb_reg = wr; wb_data = wd;
    md_valid = mv; md_reg = mr; md_data = mdat;
    q_reg1 = r1; q_reg2 = r2;
    #1;
    check_output();
    model_update();
  endtask

  task automatic idle();
    apply_stimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
  endtask

  // Asynchronous reset between edges; outputs must clear immediately.
  task automatic async_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    wb_we = 1'b0; md_valid = 1'b0; q_reg1 = '0; q_reg2 = '0;
    #1;
    chk("rst_rf_we",    32'(rf_we),     32'd0);
    chk("rst_rf_wreg",  32'(rf_wreg),   32'd0);
    chk("rst_rf_wdata", rf_wdata,       32'd0);
    chk("rst_md_pend",  32'(md_pend),   32'd0);
    chk("rst_stall",    32'(stall_req), 32'd0);
    chk("rst_md_ready", 32'(md_ready),  32'd1);
    mq.delete();
    exp_we = 1'b0; exp_wreg = '0; exp_wdata = '0; lost = 0; exp_stall = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    // Power-on reset
    #12;
    chk("por_rf_we",    32'(rf_we),    32'd0);
    chk("por_md_ready", 32'(md_ready), 32'd1);
    chk("por_md_pend",  32'(md_pend),  32'd0);
    @(negedge clk);
    rst = 1'b1;
    idle();
    chk("rel_rf_we", 32'(rf_we), 32'd0);

    // WB only: result one cycle later
    apply_stimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    idle();
    chk("wb_only_we",   32'(rf_we),   32'd1);
    chk("wb_only_reg",  32'(rf_wreg), 32'd5);
    chk("wb_only_data", rf_wdata,     32'hDEADBEEF);
    idle();
    chk("hold_reg",  32'(rf_wreg), 32'd5);
    chk("hold_data", rf_wdata,     32'hDEADBEEF);

    // MD only: pending for one cycle, written two cycles after acceptance
    apply_stimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h12, 5'd9, 5'd0);
    apply_stimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0);
    chk("md_only_pend1", 32'(md_pend), 32'd1);
    chk("md_only_hit1",  32'(q_hit1),  32'd1);
    chk("md_only_we1",   32'(rf_we),   32'd0);
    idle();
    chk("md_only_we",   32'(rf_we),   32'd1);
    chk("md_only_reg",  32'(rf_wreg), 32'd9);
    chk("md_only_pend", 32'(md_pend), 32'd0);

    // Full queue under continuous WB
    apply_stimulus(1'b1, 5'd20, 32'hA0, 1'b1, 5'd3,  32'h33, 5'd3, 5'd0);
    apply_stimulus(1'b1, 5'd20, 32'hA1, 1'b1, 5'd7,  32'h77, 5'd3, 5'd7);
    apply_stimulus(1'b1, 5'd20, 32'hA2, 1'b1, 5'd11, 32'hBB, 5'd7, 5'd3);
    chk("full_ready", 32'(md_ready), 32'd0);
    chk("full_hit1",  32'(q_hit1),   32'd1);
    chk("full_hit2",  32'(q_hit2),   32'd1);
    apply_stimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'hBB, 5'd11, 5'd0);
    chk("full_no_pop_accept", 32'(md_ready), 32'd0);
    apply_stimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'hBB, 5'd11, 5'd7);
    chk("after_pop_ready", 32'(md_ready), 32'd1);
    chk("pop_order_reg",   32'(rf_wreg),  32'd3);
    idle();
    idle();
    idle();

    // Register 0 handling
    apply_stimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55, 5'd0, 5'd0);
    idle();
    chk("r0_md_pend", 32'(md_pend), 32'd0);
    idle();
    chk("r0_no_we", 32'(rf_we), 32'd0);
    apply_stimulus(1'b1, 5'd8, 32'h80, 1'b1, 5'd14, 32'hE0, 5'd0, 5'd14);
    apply_stimulus(1'b1, 5'd0, 32'h99, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    idle();
    chk("wb_r0_md_reg",  32'(rf_wreg), 32'd14);
    chk("wb_r0_md_data", rf_wdata,     32'hE0);

    // Reset with two queued entries
    apply_stimulus(1'b1, 5'd2, 32'h22, 1'b1, 5'd4, 32'h44, 5'd4, 5'd0);
    apply_stimulus(1'b1, 5'd2, 32'h23, 1'b1, 5'd6, 32'h66, 5'd4, 5'd6);
    async_reset();
    idle();
    chk("post_rst_we", 32'(rf_we), 32'd0);
    idle();
    chk("post_rst_we2", 32'(rf_we),    32'd0);
    chk("post_rst_rdy", 32'(md_ready), 32'd1);

`ifdef REGFILE_ARB_STARVE_EN
    // Starvation: one queued entry, WB for eight cycles
    apply_stimulus(1'b1, 5'd1, 32'h100, 1'b1, 5'd13, 32'hD0, 5'd0, 5'd0);
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1'b1, 5'd1, 32'h101 + 32'(i), 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    end
    chk("starve_stall", 32'(stall_req), 32'd1);
    idle();
    idle();
    chk("starve_clear", 32'(stall_req), 32'd0);
    chk("starve_issue", 32'(rf_wreg),   32'd13);
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      apply_stimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
                     1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
                     5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, is the number of consecutive cycles a queued MD result may lose arbitration before stall_req asserts (range 1..15).
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 wb_we / wb_reg / wb_data  input  1/5/32  pipeline writeback request; no back-pressure, never dropped.
REQ-005 md_valid / md_reg / md_data  input  1/5/32  multi-cycle mul/div result offer.
REQ-006 md_ready  output  1  MD offer accepted this cycle when md_valid&&md_ready.
REQ-007 rf_we / rf_wreg / rf_wdata  output  1/5/32  registered write port driving RegWrite/Wreg/Wdata of the register file.
REQ-008 q_reg1 / q_reg2  input  5/5  source registers of the instruction in decode.
REQ-009 q_hit1 / q_hit2  output  1/1  queued MD entry targets q_reg1 / q_reg2.
REQ-010 md_pend  output  1  MD queue non-empty.
REQ-011 stall_req  output  1  request to the hazard unit to suppress wb_we.

Function
REQ-012 MD queue SHALL be a 2-entry FIFO of {reg, data}; md_ready = queue not full, computed from registered count only (no same-cycle pop-then-push when full).
REQ-013 Accepted MD offers with md_reg==0 SHALL be consumed (md_ready handshake completes) and discarded, never enqueued.
REQ-014 Per cycle: wb_we&&wb_reg!=0 SHALL win the port; otherwise a non-empty queue SHALL issue and pop its head; otherwise rf_we=0 next cycle.
REQ-015 wb_we with wb_reg==0 SHALL be treated as no request, freeing the port for MD.
REQ-016 Latency: WB request in cycle N SHALL appear on rf_* in cycle N+1; MD accepted in cycle N SHALL appear on rf_* no earlier than N+2.
REQ-017 MD entries SHALL issue in acceptance order; rf_wreg/rf_wdata SHALL hold their last values when rf_we=0.
REQ-018 Simultaneous push and pop on a 1-entry queue SHALL leave count at 1 with the new entry at head.
REQ-019 q_hit1/q_hit2 SHALL be combinational compares against valid queue entries only, forced 0 for register 0.
REQ-020 md_pend SHALL equal (count!=0), combinational from registered count.

Reset
REQ-021 rst low SHALL asynchronously clear queue count, pointers, starvation counter, rf_we, rf_wreg, rf_wdata, stall_req to 0; md_ready SHALL read 1 after release.
REQ-022 Reset mid-operation SHALL discard queued entries without issuing them; no rf_we pulse in the first cycle after release.

Configuration
REQ-023 Macro REGFILE_ARB_STARVE_EN defined: 4-bit starvation counter increments each cycle the queue is non-empty and WB wins, clears on any MD issue or empty queue; stall_req registers 1 when counter reaches STARVE_LIMIT, deasserts the cycle after the head issues.
REQ-024 Macro undefined: counter absent, stall_req tied 0; WB priority otherwise unchanged.
REQ-025 With the macro, a wb_we asserted while stall_req=1 SHALL still win (WB never lost).

Structure
REQ-026 Shared package SHALL hold REG_ADDR_W=5, DATA_W=32, MD_Q_DEPTH=2 and the {reg,data} entry typedef.
REQ-027 One sub-module regfile_md_fifo (2-entry FIFO with entry compare outputs) is natural; arbitration and starvation logic stay in the top.

Verification
REQ-028 WB only: wb_we=1, wb_reg=5, wb_data=0xDEADBEEF cycle N -> rf_we=1, rf_wreg=5, rf_wdata=0xDEADBEEF cycle N+1.
REQ-029 MD only: md_valid with reg=9, data=0x12 cycle N, no WB -> rf_we=1, rf_wreg=9 cycle N+2; md_pend 1 in N+1 only.
REQ-030 Full queue: three back-to-back MD offers under continuous WB -> md_ready=0 after two accepts; q_hit1=1 for q_reg1 matching either entry; third accepted only after a pop.
REQ-031 Register 0: md_reg=0 accepted -> md_pend stays 0, no rf_we; wb_reg=0 with queued entry -> MD issues that cycle.
REQ-032 Starvation (macro on, STARVE_LIMIT=4): queue 1 entry, wb_we=1 for 8 cycles -> stall_req=1 after 4 lost cycles; drop wb_we -> head issues, stall_req 0 next cycle.
REQ-033 Async reset with 2 queued entries mid-stream -> outputs 0 immediately, no MD write after release, md_ready=1.
